// File: rtl/ctrl_issue.sv
// Decode-to-execute issue control: decodes opcodeD, handles stall/flush and the execute register.
// Define CTRL_MUL_EN to build the multi-cycle MUL sequencer (MUL_BUSY state and counter).
module ctrl_issue #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instrValid,
  input  logic [3:0] opcodeD,
  input  logic       stallIn,
  input  logic       PCSrcE,
  output logic       flagUpdate,
  output logic       PCS,
  output logic       regW,
  output logic       memWriteSrc,
  output logic       memToReg,
  output logic [3:0] opcodeE,
  output logic       stallF,
  output logic       flushD,
  output logic       illegalOp,
  output logic       busy
);

  typedef struct packed {
    logic       flag_update;
    logic       pcs;
    logic       reg_w;
    logic       mem_write;
    logic       mem_to_reg;
    logic [3:0] opcode;
  } ex_bundle_t;

  localparam ex_bundle_t Bubble = '0;

  ex_bundle_t dec_bundle;
  ex_bundle_t ex_d, ex_q;
  logic       dec_illegal;
  logic       illegal_d, illegal_q;
  logic       mul_busy;
  logic       mul_last;
`ifdef CTRL_MUL_EN
  logic       dec_is_mul;
`endif

  always_comb begin
    dec_bundle  = Bubble;
    dec_illegal = 1'b0;
`ifdef CTRL_MUL_EN
    dec_is_mul  = 1'b0;
`endif
    if (instrValid) begin
      dec_bundle.opcode = opcodeD;
      case (opcodeD)
        4'h0: ;
        4'h1, 4'h2, 4'h3, 4'h4: dec_bundle.reg_w = 1'b1;
        4'h5: dec_bundle.flag_update = 1'b1;
        4'h6: begin
          dec_bundle.reg_w      = 1'b1;
          dec_bundle.mem_to_reg = 1'b1;
        end
        4'h7, 4'h8: dec_bundle.pcs = 1'b1;
        4'h9: dec_bundle.mem_write = 1'b1;
`ifdef CTRL_MUL_EN
        4'hA: begin
          dec_bundle.reg_w = 1'b1;
          dec_is_mul       = 1'b1;
        end
`endif
        default: dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
        dec_bundle = Bubble;
      end
    end
  end

  // On MUL completion decode is still held by stallF, so a bubble (not the decode bundle) enters.
  always_comb begin
    ex_d      = ex_q;
    illegal_d = 1'b0;
    if (PCSrcE) begin
      ex_d = Bubble;
    end else if (mul_busy) begin
      if (mul_last && !stallIn) begin
        ex_d = Bubble;
      end
    end else if (!stallIn) begin
      ex_d      = dec_bundle;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= Bubble;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef CTRL_MUL_EN
  typedef enum logic [0:0] {StRun, StMulBusy} state_e;

  localparam logic [3:0] MulCntInit = 4'(MUL_CYCLES - 1);

  state_e     state_d, state_q;
  logic [3:0] cnt_d, cnt_q;

  assign mul_busy = (state_q == StMulBusy);
  assign mul_last = mul_busy && (cnt_q == 4'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (!PCSrcE && !stallIn && dec_is_mul && (MUL_CYCLES > 1)) begin
          state_d = StMulBusy;
          cnt_d   = MulCntInit;
        end
      end
      StMulBusy: begin
        if (PCSrcE) begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end else if (!stallIn) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StRun;
          end
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_mul_cycles;

  assign unused_mul_cycles = ^MUL_CYCLES;
  assign mul_busy          = 1'b0;
  assign mul_last          = 1'b0;
`endif

  // During MUL_BUSY the write request is held back until the final occupancy cycle.
  assign regW        = mul_busy ? mul_last : ex_q.reg_w;
  assign flagUpdate  = ex_q.flag_update;
  assign PCS         = ex_q.pcs;
  assign memWriteSrc = ex_q.mem_write;
  assign memToReg    = ex_q.mem_to_reg;
  assign opcodeE     = ex_q.opcode;
  assign illegalOp   = illegal_q;
  assign busy        = mul_busy;
  assign flushD      = reset & PCSrcE;
  assign stallF      = reset & ~PCSrcE & (stallIn | mul_busy);

endmodule

// File: tb/tb_ctrl_issue.sv
// Self-checking bench for ctrl_issue: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the issue rules.
module tb_ctrl_issue;

  localparam int unsigned MulCycles = 3;
`ifdef CTRL_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instrValid = 1'b0;
  logic [3:0] opcodeD = 4'd0;
  logic       stallIn = 1'b0;
  logic       PCSrcE = 1'b0;
  logic       flagUpdate, PCS, regW, memWriteSrc, memToReg;
  logic [3:0] opcodeE;
  logic       stallF, flushD, illegalOp, busy;

  int checks = 0;
  int errors = 0;

  // Model: execute bundle {fu, pcs, rw, mw, mtr, op[3:0]}, pending illegal flag, MUL cycles left.
  logic [8:0] m_ex;
  logic       m_ill;
  int         m_left;

  always #5 clk = ~clk;

  ctrl_issue #(
    .MUL_CYCLES(MulCycles)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instrValid (instrValid),
    .opcodeD    (opcodeD),
    .stallIn    (stallIn),
    .PCSrcE     (PCSrcE),
    .flagUpdate (flagUpdate),
    .PCS        (PCS),
    .regW       (regW),
    .memWriteSrc(memWriteSrc),
    .memToReg   (memToReg),
    .opcodeE    (opcodeE),
    .stallF     (stallF),
    .flushD     (flushD),
    .illegalOp  (illegalOp),
    .busy       (busy)
  );

  function automatic logic ref_illegal(input logic v, input logic [3:0] op);
    return v && (op >= 4'd11 || (op == 4'd10 && !MulEn));
  endfunction

  function automatic logic [8:0] ref_decode(input logic v, input logic [3:0] op);
    logic fu, pcs, rw, mw, mtr;
    fu = 1'b0; pcs = 1'b0; rw = 1'b0; mw = 1'b0; mtr = 1'b0;
    if (!v || ref_illegal(v, op)) return 9'd0;
    if (op >= 4'd1 && op <= 4'd4) rw = 1'b1;
    if (op == 4'd5) fu = 1'b1;
    if (op == 4'd6) begin rw = 1'b1; mtr = 1'b1; end
    if (op == 4'd7 || op == 4'd8) pcs = 1'b1;
    if (op == 4'd9) mw = 1'b1;
    if (op == 4'd10) rw = 1'b1;
    return {fu, pcs, rw, mw, mtr, op};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {flagUpdate, PCS, regW, memWriteSrc, memToReg, opcodeE, stallF, flushD, illegalOp, busy};
  endfunction

  function automatic logic [12:0] exp_vec();
    logic b, rw;
    b  = (m_left > 0);
    rw = b ? (m_left == 1) : m_ex[6];
    if (!reset) return 13'd0;
    return {m_ex[8:7], rw, m_ex[5:0], !PCSrcE && (stallIn || b), PCSrcE, m_ill, b};
  endfunction

  // Advance the model across the coming rising edge using the inputs currently applied.
  task automatic advance();
    if (!reset || PCSrcE) begin
      m_ex = 9'd0; m_ill = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_ill = 1'b0;
      if (!stallIn) begin
        m_left--;
        if (m_left == 0) m_ex = 9'd0;
      end
    end else if (stallIn) begin
      m_ill = 1'b0;
    end else begin
      m_ex  = ref_decode(instrValid, opcodeD);
      m_ill = ref_illegal(instrValid, opcodeD);
      if (instrValid && opcodeD == 4'd10 && MulEn && MulCycles > 1) m_left = int'(MulCycles) - 1;
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic st, input logic pc);
    @(negedge clk);
    instrValid = v; opcodeD = op; stallIn = st; PCSrcE = pc;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 4'd1, 1'b1, 1'b1);
    checks++;
    if (obs_vec() !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), 13'd0);
    end
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    checks++;
    if (opcodeE !== 4'd0 || regW !== 1'b0) begin
      errors++; $display("FAIL reset_hold_edge: opcodeE=%b regW=%b expected 0000/0", opcodeE, regW);
    end
    drive(1'b1, 4'd1, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %b expected %b", obs_vec(), exp_vec());
    end
    advance();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (opcodeE !== 4'd1 || regW !== 1'b1) begin
      errors++; $display("FAIL first_load: opcodeE=%b regW=%b expected 0001/1", opcodeE, regW);
    end
    advance();
  endtask

  task automatic test_alu_seq();
    logic [3:0] ops [4];
    ops = '{4'd1, 4'd5, 4'd9, 4'd0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL alu_seq[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (opcodeE !== 4'b0001 || regW !== 1'b1) begin
          errors++; $display("FAIL alu_add: opcodeE=%b regW=%b expected 0001/1", opcodeE, regW);
        end
      end
      if (i == 2) begin
        checks++;
        if (flagUpdate !== 1'b1) begin
          errors++; $display("FAIL alu_cmp: flagUpdate=%b expected 1", flagUpdate);
        end
      end
      if (i == 3) begin
        checks++;
        if (memWriteSrc !== 1'b1) begin
          errors++; $display("FAIL alu_str: memWriteSrc=%b expected 1", memWriteSrc);
        end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 4'd8, 1'b0, 1'b0);
    advance();
    drive(1'b1, 4'd1, 1'b1, 1'b1);
    checks++;
    if (flushD !== 1'b1 || stallF !== 1'b0 || PCS !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle: flushD=%b stallF=%b PCS=%b expected 1/0/1", flushD, stallF, PCS);
    end
    advance();
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 13'd0) begin
      errors++; $display("FAIL flush_bubble: got %b expected %b", obs_vec(), 13'd0);
    end
    advance();
  endtask

  task automatic test_illegal();
    logic [3:0] ops [5];
    logic       sts [5];
    ops = '{4'd12, 4'd10, 4'd15, 4'd0, 4'd0};
    sts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ops[i], sts[i], 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL illegal[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (illegalOp !== 1'b1 || opcodeE !== 4'd0 || regW !== 1'b0) begin
          errors++;
          $display("FAIL illegal_1100: illegalOp=%b opcodeE=%b regW=%b expected 1/0000/0",
                   illegalOp, opcodeE, regW);
        end
      end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL illegal_drain[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

`ifdef CTRL_MUL_EN
  task automatic test_mul();
    int n_busy, n_rw, rw_at;
    n_busy = 0; n_rw = 0; rw_at = -1;
    drive(1'b1, 4'd10, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd1, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mul[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (busy === 1'b1) n_busy++;
      if (busy === 1'b1 && stallF === 1'b1 && regW === 1'b1) begin n_rw++; rw_at = n_busy; end
      advance();
    end
    checks++;
    if (n_busy != int'(MulCycles) - 1 || n_rw != 1 || rw_at != n_busy) begin
      errors++;
      $display("FAIL mul_occupancy: busy=%0d regw=%0d at=%0d expected %0d/1/%0d",
               n_busy, n_rw, rw_at, MulCycles - 1, MulCycles - 1);
    end
    n_busy = 0;
    drive(1'b1, 4'd10, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'd3, (i < 2), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mul_stall[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (busy === 1'b1) n_busy++;
      advance();
    end
    checks++;
    if (n_busy != int'(MulCycles) + 1) begin
      errors++; $display("FAIL mul_stall_len: busy=%0d expected %0d", n_busy, MulCycles + 1);
    end
    drive(1'b1, 4'd10, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd4, 1'b1, (i == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mul_flush[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [3:0] op;
    op = MulEn ? 4'd10 : 4'd1;
    drive(1'b1, op, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'd1, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL areset_pre[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (i == 0) advance();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 13'd0) begin
      errors++; $display("FAIL areset_immediate: got %b expected %b", obs_vec(), 13'd0);
    end
    m_ex = 9'd0; m_ill = 1'b0; m_left = 0;
    drive(1'b1, 4'd1, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL areset_held: got %b expected %b", obs_vec(), exp_vec());
    end
    reset = 1'b1;
    PCSrcE = 1'b0;
    #1;
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL areset_post[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0, 4'($urandom_range(15, 0)),
            $urandom_range(4, 0) == 0, $urandom_range(7, 0) == 0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    m_ex = 9'd0; m_ill = 1'b0; m_left = 0;
    test_reset();
    test_alu_seq();
    test_flush();
    test_illegal();
`ifdef CTRL_MUL_EN
    test_mul();
`endif
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
